// File: rtl/binary_frame_reader_if.sv
// Byte stream from binary_frame_reader toward the serial/host link.
// The master drives oByte/oValid; the sink drives iReady.
interface binary_frame_reader_if;
  logic [7:0] oByte;
  logic       oValid;
  logic       iReady;

  modport master (output oByte, output oValid, input iReady);
  modport slave  (input oByte, input oValid, output iReady);
endinterface

// File: rtl/binary_frame_reader.sv
// Streams the 1-bit result memory from START_POS to END_POS as MSB-first packed bytes.
// Optional FRAME_HEADER_EN: emits a 8'hA5 header byte before the pixel bytes of each frame.
module binary_frame_reader #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int WIDTH       = 2**WIDTH_BITS,
  parameter int HEIGHT      = 2**HEIGHT_BITS,
  parameter int START_POS   = 0,
  parameter int END_POS     = WIDTH*HEIGHT-1
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   start,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  input  logic                   iResultData,
  output logic                   busy,
  output logic                   finished,
  binary_frame_reader_if.master  stream
);
  localparam int PW = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [PW-1:0] START_P = PW'(START_POS);
  localparam logic [PW-1:0] END_P   = PW'(END_POS);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, SEND, DONE
`ifdef FRAME_HEADER_EN
    , HEADER
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;

  logic [7:0]    sh_n;
  logic [3:0]    cnt_n;
  logic          hs;
  logic          last_pos;

  assign sh_n     = {shift_q[6:0], iResultData};
  assign cnt_n    = bitcnt_q + 4'd1;
  assign hs       = valid_q && stream.iReady;
  assign last_pos = (pos_q == END_P);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pos_d    = START_P;
          shift_d  = '0;
          bitcnt_d = '0;
`ifdef FRAME_HEADER_EN
          byte_d   = 8'hA5;
          valid_d  = 1'b1;
          state_d  = HEADER;
`else
          state_d  = FETCH;
`endif
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        shift_d  = sh_n;
        bitcnt_d = cnt_n;
        if (bitcnt_q == 4'd7 || last_pos) begin
          // Left-align a short final byte; a full byte shifts by zero.
          byte_d  = sh_n << (4'd8 - cnt_n);
          valid_d = 1'b1;
          state_d = SEND;
        end else begin
          pos_d   = pos_q + 1'b1;
          state_d = FETCH;
        end
      end
      SEND: begin
        if (hs) begin
          valid_d  = 1'b0;
          shift_d  = '0;
          bitcnt_d = '0;
          if (last_pos) begin
            state_d = DONE;
          end else begin
            pos_d   = pos_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
`ifdef FRAME_HEADER_EN
      HEADER: begin
        if (hs) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!not_reset) begin
      state_q  <= IDLE;
      pos_q    <= START_P;
      shift_q  <= '0;
      bitcnt_q <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
    end
  end

  assign oResultCol    = pos_q[WIDTH_BITS-1:0];
  assign oResultRow    = pos_q[PW-1:WIDTH_BITS];
  assign stream.oByte  = byte_q;
  assign stream.oValid = valid_q;
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign finished      = (state_q == DONE);
endmodule

// File: tb/tb_binary_frame_reader.sv
// Directed + randomized bench for binary_frame_reader with a pixel-list reference model.
module tb_binary_frame_reader;
  logic clock = 1'b0;
  logic not_reset;
  logic start1, start2;
  logic [2:0] col1, col2;
  logic [1:0] row1, row2;
  logic rd1, rd2;
  logic busy1, busy2, fin1, fin2;

  binary_frame_reader_if s1();
  binary_frame_reader_if s2();

  binary_frame_reader #(.WIDTH_BITS(3), .HEIGHT_BITS(2)) dut (
    .clock(clock), .not_reset(not_reset), .start(start1),
    .oResultCol(col1), .oResultRow(row1), .iResultData(rd1),
    .busy(busy1), .finished(fin1), .stream(s1));

  binary_frame_reader #(.WIDTH_BITS(3), .HEIGHT_BITS(2), .START_POS(0), .END_POS(10)) dut2 (
    .clock(clock), .not_reset(not_reset), .start(start2),
    .oResultCol(col2), .oResultRow(row2), .iResultData(rd2),
    .busy(busy2), .finished(fin2), .stream(s2));

  always #5 clock = ~clock;

  int mode;
  logic [31:0] rmem;
  logic [7:0] q1[$], q2[$], exp_q[$];
  int tests = 0, fails = 0;

  function automatic logic pix(input int a);
    case (mode)
      0: return (a % 3) == 0;
      1: return 1'b1;
      default: return rmem[a];
    endcase
  endfunction

  // Memory read port: data one cycle after the address.
  always @(posedge clock) begin
    rd1 <= pix(int'({row1, col1}));
    rd2 <= pix(int'({row2, col2}));
  end

  always @(posedge clock) begin
    if (not_reset && s1.oValid && s1.iReady) q1.push_back(s1.oByte);
    if (not_reset && s2.oValid && s2.iReady) q2.push_back(s2.oByte);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic build_exp(input int endp);
    logic [7:0] b;
    exp_q.delete();
`ifdef FRAME_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i <= endp; i += 8) begin
      b = '0;
      for (int j = 0; j < 8; j++)
        if (i + j <= endp) b[7-j] = pix(i + j);
      exp_q.push_back(b);
    end
  endtask

  task automatic cmp_frame(input string tag, input int which);
    int n;
    logic [31:0] a;
    n = (which == 2) ? q2.size() : q1.size();
    check({tag, "_count"}, n, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < n) a = (which == 2) ? {24'd0, q2[k]} : {24'd0, q1[k]};
      else a = 32'hFFFF_FFFF;
      check($sformatf("%s_byte%0d", tag, k), a, {24'd0, exp_q[k]});
    end
  endtask

  task automatic pulse1;
    @(negedge clock) start1 = 1'b1;
    @(negedge clock) start1 = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int which, input bit rnd);
    int n = 0;
    while (((which == 2) ? fin2 : fin1) !== 1'b1 && n < 3000) begin
      @(negedge clock);
      if (rnd) s1.iReady = 1'($urandom_range(0, 1));
      n++;
    end
    s1.iReady = 1'b1;
    check({tag, "_finished"}, (which == 2) ? fin2 : fin1, 1);
  endtask

  initial begin
    int n;
    logic [2:0] hc;
    logic [1:0] hr;
    not_reset = 1'b0; start1 = 1'b0; start2 = 1'b0;
    s1.iReady = 1'b1; s2.iReady = 1'b1;
    mode = 0; rmem = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy1, 0);
    check("rst_finished", fin1, 0);
    check("rst_valid", s1.oValid, 0);
    check("rst_byte", s1.oByte, 0);
    check("rst_addr", {row1, col1}, 0);
    not_reset = 1'b1;
    @(negedge clock);

    // Basic frame, sink always ready.
    build_exp(31);
    q1.delete();
    pulse1();
    check("s1_busy", busy1, 1);
    wait_fin("s1", 1, 0);
    cmp_frame("s1", 1);
    check("s1_busy_end", busy1, 0);
    check("s1_valid_end", s1.oValid, 0);

    // Sink stalls for 5 cycles on the first byte.
    q1.delete();
    s1.iReady = 1'b0;
    pulse1();
    n = 0;
    while (s1.oValid !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    check("stall_seen", s1.oValid, 1);
    hc = col1; hr = row1;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", s1.oValid, 1);
      check("stall_byte", s1.oByte, exp_q[0]);
      check("stall_addr", {row1, col1}, {hr, hc});
      @(negedge clock);
    end
    check("stall_none", q1.size(), 0);
    s1.iReady = 1'b1;
    wait_fin("stall", 1, 0);
    cmp_frame("stall", 1);

    // Short frame of 11 ones on the second instance.
    mode = 1;
    build_exp(10);
    q2.delete();
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
    wait_fin("short", 2, 0);
    cmp_frame("short", 2);

    // Reset right after the second handshake, then restream.
    mode = 0;
    build_exp(31);
    q1.delete();
    pulse1();
    n = 0;
    while (q1.size() < 2 && n < 200) begin @(negedge clock); n++; end
    check("rst2_reached", q1.size(), 2);
    not_reset = 1'b0;
    @(negedge clock);
    not_reset = 1'b1;
    check("rst2_busy", busy1, 0);
    check("rst2_finished", fin1, 0);
    check("rst2_valid", s1.oValid, 0);
    check("rst2_byte", s1.oByte, 0);
    check("rst2_addr", {row1, col1}, 0);
    q1.delete();
    pulse1();
    wait_fin("rst2", 1, 0);
    cmp_frame("rst2", 1);

    // start while busy is ignored; start in DONE restreams.
    q1.delete();
    pulse1();
    repeat (6) @(negedge clock);
    check("busy_start_busy", busy1, 1);
    pulse1();
    wait_fin("ign", 1, 0);
    cmp_frame("ign", 1);
    q1.delete();
    @(negedge clock) start1 = 1'b1;
    @(negedge clock) start1 = 1'b0;
    check("restart_fin", fin1, 0);
    check("restart_busy", busy1, 1);
    wait_fin("restart", 1, 0);
    cmp_frame("restart", 1);

    // Random images with random sink back-pressure.
    mode = 2;
    for (int f = 0; f < 3; f++) begin
      rmem = $urandom;
      build_exp(31);
      q1.delete();
      pulse1();
      wait_fin("rnd", 1, 1);
      cmp_frame($sformatf("rnd%0d", f), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
